// File: rtl/sisp_ctx_loader.sv
// sisp_ctx_loader: runs one descriptor as MODE write, CFG write, data burst, wait, readback sweep.
// Optional readback checksum output csum_o: define SISP_CTX_READBACK_CSUM_EN.
module sisp_ctx_loader #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 8,
    parameter int LEN_W     = 8,
    parameter int WAIT_W    = 16,
    parameter int MODE_ADDR = 140,
    parameter int CFG_ADDR  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [5:0]        mode_i,
    input  logic [DATA_W-1:0] cfg_i,
    input  logic [ADDR_W-1:0] burst_addr_i,
    input  logic [LEN_W-1:0]  burst_len_i,
    input  logic [WAIT_W-1:0] wait_cycles_i,
    input  logic [ADDR_W-1:0] rd_base_i,
    input  logic [LEN_W-1:0]  rd_len_i,
    input  logic [DATA_W-1:0] src_data_i,
    input  logic              src_valid_i,
    output logic              src_ready_o,
    input  logic              sisp_stall_i,
    output logic [ADDR_W-1:0] ctx_addr_o,
    output logic [DATA_W-1:0] ctx_data_o,
    output logic              ctx_we_o,
    output logic              ctx_rd_o,
    input  logic [DATA_W-1:0] sisp_dout_i,
    input  logic              sisp_dout_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
`ifdef SISP_CTX_READBACK_CSUM_EN
    output logic [DATA_W-1:0] csum_o,
`endif
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MODE,
        S_CFG,
        S_BURST,
        S_WAIT,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [5:0]        mode_q, mode_d;
    logic [DATA_W-1:0] cfg_q, cfg_d;
    logic [ADDR_W-1:0] burst_addr_q, burst_addr_d;
    logic [LEN_W-1:0]  burst_len_q, burst_len_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ADDR_W-1:0] rd_base_q, rd_base_d;
    logic [LEN_W-1:0]  rd_len_q, rd_len_d;
    logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [LEN_W-1:0]  cap_cnt_q, cap_cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
`ifdef SISP_CTX_READBACK_CSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    logic start_accept;
    logic src_fire;
    logic rd_issue;
    logic cap_fire;

    // Source stream handshake: a word moves on every cycle where src_valid_i and
    // src_ready_o are both high; ready never depends on valid, and it goes low
    // whenever SISP stalls, so a stalled word simply waits on the source side.
    assign start_accept = (state_q == S_IDLE) && start_i;
    assign src_fire     = (state_q == S_BURST) && src_valid_i && !sisp_stall_i;
    assign rd_issue     = (state_q == S_READ) && !sisp_stall_i;
    assign cap_fire     = ((state_q == S_READ) || (state_q == S_DRAIN))
                          && sisp_dout_ready_i && (cap_cnt_q != rd_len_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Zero-length phases are skipped at the transition, so an empty descriptor
    // runs MODE, CFG, DONE back to back.
    always_comb begin
        state_t after_wait_st;
        state_t after_burst_st;
        after_wait_st  = (rd_len_q != '0) ? S_READ : S_DONE;
        after_burst_st = (wait_q != '0) ? S_WAIT : after_wait_st;
        state_d        = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_MODE;
                end
            end
            S_MODE: begin
                if (!sisp_stall_i) begin
                    state_d = S_CFG;
                end
            end
            S_CFG: begin
                if (!sisp_stall_i) begin
                    state_d = (burst_len_q != '0) ? S_BURST : after_burst_st;
                end
            end
            S_BURST: begin
                if (src_fire && (word_cnt_q == burst_len_q - LEN_W'(1))) begin
                    state_d = after_burst_st;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == wait_q - WAIT_W'(1)) begin
                    state_d = after_wait_st;
                end
            end
            S_READ: begin
                if (rd_issue && (word_cnt_q == rd_len_q - LEN_W'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cap_cnt_q == rd_len_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        src_ready_o = 1'b0;
        ctx_addr_o  = '0;
        ctx_data_o  = '0;
        ctx_we_o    = 1'b0;
        ctx_rd_o    = 1'b0;
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        case (state_q)
            S_MODE: begin
                ctx_addr_o = ADDR_W'(MODE_ADDR);
                ctx_data_o = DATA_W'(mode_q);
                ctx_we_o   = !sisp_stall_i;
            end
            S_CFG: begin
                ctx_addr_o = ADDR_W'(CFG_ADDR);
                ctx_data_o = cfg_q;
                ctx_we_o   = !sisp_stall_i;
            end
            S_BURST: begin
                // Data and strobe pass straight through so the burst adds no latency.
                src_ready_o = !sisp_stall_i;
                ctx_addr_o  = burst_addr_q;
                ctx_data_o  = src_data_i;
                ctx_we_o    = src_valid_i && !sisp_stall_i;
            end
            S_READ: begin
                ctx_addr_o = rd_base_q + ADDR_W'(word_cnt_q);
                ctx_rd_o   = !sisp_stall_i;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        mode_d       = mode_q;
        cfg_d        = cfg_q;
        burst_addr_d = burst_addr_q;
        burst_len_d  = burst_len_q;
        wait_d       = wait_q;
        rd_base_d    = rd_base_q;
        rd_len_d     = rd_len_q;
        word_cnt_d   = word_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        cap_cnt_d    = cap_cnt_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = cap_fire;
`ifdef SISP_CTX_READBACK_CSUM_EN
        csum_d       = csum_q;
`endif
        if (start_accept) begin
            mode_d       = mode_i;
            cfg_d        = cfg_i;
            burst_addr_d = burst_addr_i;
            burst_len_d  = burst_len_i;
            wait_d       = wait_cycles_i;
            rd_base_d    = rd_base_i;
            rd_len_d     = rd_len_i;
            cap_cnt_d    = '0;
`ifdef SISP_CTX_READBACK_CSUM_EN
            csum_d       = '0;
`endif
        end
        // Per-phase counters restart on every state change.
        if (state_d != state_q) begin
            word_cnt_d = '0;
            wait_cnt_d = '0;
        end else begin
            if (src_fire || rd_issue) begin
                word_cnt_d = word_cnt_q + LEN_W'(1);
            end
            if (state_q == S_WAIT) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end
        if (cap_fire) begin
            cap_cnt_d = cap_cnt_q + LEN_W'(1);
            rd_data_d = sisp_dout_i;
`ifdef SISP_CTX_READBACK_CSUM_EN
            csum_d    = csum_q ^ sisp_dout_i;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= '0;
            cfg_q        <= '0;
            burst_addr_q <= '0;
            burst_len_q  <= '0;
            wait_q       <= '0;
            rd_base_q    <= '0;
            rd_len_q     <= '0;
            word_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            cap_cnt_q    <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
`ifdef SISP_CTX_READBACK_CSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            mode_q       <= mode_d;
            cfg_q        <= cfg_d;
            burst_addr_q <= burst_addr_d;
            burst_len_q  <= burst_len_d;
            wait_q       <= wait_d;
            rd_base_q    <= rd_base_d;
            rd_len_q     <= rd_len_d;
            word_cnt_q   <= word_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            cap_cnt_q    <= cap_cnt_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
`ifdef SISP_CTX_READBACK_CSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
`ifdef SISP_CTX_READBACK_CSUM_EN
    assign csum_o     = csum_q;
`endif

endmodule

// File: tb/tb_sisp_ctx_loader.sv
// Testbench for sisp_ctx_loader: descriptor table plus hand-written reset sequence,
// with a latency-2 SISP model that answers each read with addr+1000.
module tb_sisp_ctx_loader;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 8;
    localparam int WAIT_W = 16;

    logic              clk;
    logic              reset;
    logic              start_i;
    logic [5:0]        mode_i;
    logic [DATA_W-1:0] cfg_i;
    logic [ADDR_W-1:0] burst_addr_i;
    logic [LEN_W-1:0]  burst_len_i;
    logic [WAIT_W-1:0] wait_cycles_i;
    logic [ADDR_W-1:0] rd_base_i;
    logic [LEN_W-1:0]  rd_len_i;
    logic [DATA_W-1:0] src_data_i;
    logic              src_valid_i;
    logic              src_ready_o;
    logic              sisp_stall_i;
    logic [ADDR_W-1:0] ctx_addr_o;
    logic [DATA_W-1:0] ctx_data_o;
    logic              ctx_we_o;
    logic              ctx_rd_o;
    logic [DATA_W-1:0] sisp_dout_i;
    logic              sisp_dout_ready_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o;
    logic              busy_o;
    logic              done_o;
`ifdef SISP_CTX_READBACK_CSUM_EN
    logic [DATA_W-1:0] csum_o;
`endif

    sisp_ctx_loader dut (
        .clk               (clk),
        .reset             (reset),
        .start_i           (start_i),
        .mode_i            (mode_i),
        .cfg_i             (cfg_i),
        .burst_addr_i      (burst_addr_i),
        .burst_len_i       (burst_len_i),
        .wait_cycles_i     (wait_cycles_i),
        .rd_base_i         (rd_base_i),
        .rd_len_i          (rd_len_i),
        .src_data_i        (src_data_i),
        .src_valid_i       (src_valid_i),
        .src_ready_o       (src_ready_o),
        .sisp_stall_i      (sisp_stall_i),
        .ctx_addr_o        (ctx_addr_o),
        .ctx_data_o        (ctx_data_o),
        .ctx_we_o          (ctx_we_o),
        .ctx_rd_o          (ctx_rd_o),
        .sisp_dout_i       (sisp_dout_i),
        .sisp_dout_ready_i (sisp_dout_ready_i),
        .rd_data_o         (rd_data_o),
        .rd_valid_o        (rd_valid_o),
`ifdef SISP_CTX_READBACK_CSUM_EN
        .csum_o            (csum_o),
`endif
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [5:0]        mode;
        logic [DATA_W-1:0] cfg;
        logic [ADDR_W-1:0] burst_addr;
        logic [LEN_W-1:0]  burst_len;
        logic [WAIT_W-1:0] wait_cyc;
        logic [ADDR_W-1:0] rd_base;
        logic [LEN_W-1:0]  rd_len;
        bit                stall_en;
        bit                stall_mc;
        bit                gap_en;
        bit                extra_ret;
        bit                restart;
        int                exp_writes;
        int                exp_reads;
        int                exp_rdv;
        int                exp_done_rel;
        int                exp_first_wr;
        int                exp_last_rd;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(input logic [5:0] mode, input logic [DATA_W-1:0] cfg,
                                input logic [ADDR_W-1:0] ba, input logic [LEN_W-1:0] bl,
                                input logic [WAIT_W-1:0] wc, input logic [ADDR_W-1:0] rb,
                                input logic [LEN_W-1:0] rl, input bit st, input bit smc,
                                input bit gap, input bit xr, input bit rs,
                                input int ew, input int er, input int ev, input int ed,
                                input int ef, input int el);
        vec_t v;
        v.mode = mode; v.cfg = cfg; v.burst_addr = ba; v.burst_len = bl;
        v.wait_cyc = wc; v.rd_base = rb; v.rd_len = rl;
        v.stall_en = st; v.stall_mc = smc; v.gap_en = gap; v.extra_ret = xr; v.restart = rs;
        v.exp_writes = ew; v.exp_reads = er; v.exp_rdv = ev; v.exp_done_rel = ed;
        v.exp_first_wr = ef; v.exp_last_rd = el;
        return v;
    endfunction

    logic [DATA_W-1:0] burst_data[12];

    // ---------------- scoreboard ----------------
    logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];
    logic [ADDR_W-1:0]        exp_rd_q[$];
    logic [DATA_W-1:0]        exp_rdv_q[$];
    logic [DATA_W-1:0]        exp_csum;

    int total = 0;
    int bad   = 0;

    task automatic chk_v(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // per-run state
    int ptr, burst_seen, rd_seen, n_wr, n_rd, n_rdv, n_done, done_rel, first_wr;
    int last_rd, viol, ret_cnt, extra_left, stall_left;
    bit stalled_b, stalled_r;
    bit d1_v, d2_v;
    logic [ADDR_W-1:0] d1_a, d2_a;

    task automatic prep(input vec_t v);
        logic [ADDR_W-1:0] a;
        exp_wr_q.delete();
        exp_rd_q.delete();
        exp_rdv_q.delete();
        exp_csum = '0;
        exp_wr_q.push_back({8'd140, 58'd0, v.mode});
        exp_wr_q.push_back({8'd0, v.cfg});
        for (int i = 0; i < int'(v.burst_len); i++) begin
            exp_wr_q.push_back({v.burst_addr, burst_data[i]});
        end
        for (int i = 0; i < int'(v.rd_len); i++) begin
            a = v.rd_base + ADDR_W'(i);
            exp_rd_q.push_back(a);
            exp_rdv_q.push_back(DATA_W'(a) + 64'd1000);
            exp_csum = exp_csum ^ (DATA_W'(a) + 64'd1000);
        end
        ptr = 0; burst_seen = 0; rd_seen = 0; n_wr = 0; n_rd = 0; n_rdv = 0;
        n_done = 0; done_rel = -1; first_wr = -1; last_rd = -1; viol = 0;
        ret_cnt = 0; extra_left = 0; stall_left = 0; stalled_b = 0; stalled_r = 0;
        d1_v = 0; d2_v = 0; d1_a = '0; d2_a = '0;
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input vec_t v, input int rel);
        start_i = (rel == 0) || (v.restart && rel == 10);
        if (rel == 0) begin
            mode_i = v.mode; cfg_i = v.cfg; burst_addr_i = v.burst_addr;
            burst_len_i = v.burst_len; wait_cycles_i = v.wait_cyc;
            rd_base_i = v.rd_base; rd_len_i = v.rd_len;
        end else begin
            mode_i = 6'($urandom_range(0, 9));
            cfg_i = {$urandom, $urandom};
            burst_addr_i = 8'($urandom_range(0, 255));
            burst_len_i = 8'($urandom_range(1, 255));
            wait_cycles_i = 16'($urandom_range(1, 100));
            rd_base_i = 8'($urandom_range(0, 255));
            rd_len_i = 8'($urandom_range(1, 255));
        end
        src_valid_i = (ptr < int'(v.burst_len)) && (!v.gap_en || (rel % 2 == 0));
        src_data_i = (ptr < 12) ? burst_data[ptr] : 64'd0;
        if (stall_left > 0) begin
            sisp_stall_i = 1'b1;
            stall_left--;
        end else if (v.stall_en && !stalled_b && burst_seen == 5) begin
            sisp_stall_i = 1'b1; stalled_b = 1; stall_left = 2;
        end else if (v.stall_en && !stalled_r && rd_seen == 6) begin
            sisp_stall_i = 1'b1; stalled_r = 1; stall_left = 1;
        end else begin
            sisp_stall_i = v.stall_mc && (rel == 1 || rel == 2);
        end
        if (d2_v) begin
            sisp_dout_ready_i = 1'b1;
            sisp_dout_i = DATA_W'(d2_a) + 64'd1000;
            ret_cnt++;
            if (v.extra_ret && ret_cnt == int'(v.rd_len)) extra_left = 2;
        end else if (extra_left > 0) begin
            sisp_dout_ready_i = 1'b1;
            sisp_dout_i = 64'hDEAD_0000_0000_BEEF;
            extra_left--;
        end else begin
            sisp_dout_ready_i = 1'b0;
            sisp_dout_i = {$urandom, $urandom};
        end
    endtask

    // Samples the current cycle 1 time unit after inputs settle, then advances to the next negedge.
    task automatic sample(input int rel);
        #1;
        if (sisp_stall_i && (ctx_we_o || ctx_rd_o || src_ready_o)) viol++;
        if (ctx_we_o && n_wr >= 2 && !src_valid_i) viol++;
        if (ctx_we_o) begin
            if (first_wr < 0) first_wr = rel;
            if (exp_wr_q.size() == 0) begin
                total++; bad++;
                $display("FAIL wr_extra: got addr %0d data %h expected no write", ctx_addr_o, ctx_data_o);
            end else begin
                chk_v($sformatf("wr%0d", n_wr), {ctx_addr_o, ctx_data_o}, exp_wr_q.pop_front());
            end
            n_wr++;
        end
        if (src_valid_i && src_ready_o) begin
            ptr++;
            burst_seen++;
        end
        if (ctx_rd_o) begin
            if (exp_rd_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_extra: got addr %0d expected no read", ctx_addr_o);
            end else begin
                chk_v($sformatf("rd_addr%0d", n_rd), {64'd0, ctx_addr_o}, {64'd0, exp_rd_q.pop_front()});
            end
            last_rd = int'(ctx_addr_o);
            n_rd++;
            rd_seen++;
        end
        if (rd_valid_o) begin
            if (exp_rdv_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rdv_extra: got %h expected no rd_valid", rd_data_o);
            end else begin
                chk_v($sformatf("rd_data%0d", n_rdv), {8'd0, rd_data_o}, {8'd0, exp_rdv_q.pop_front()});
            end
            n_rdv++;
        end
        if (done_o) begin
            n_done++;
            done_rel = rel;
`ifdef SISP_CTX_READBACK_CSUM_EN
            chk_v("csum", {8'd0, csum_o}, {8'd0, exp_csum});
`endif
        end
        d2_v = d1_v; d2_a = d1_a;
        d1_v = ctx_rd_o; d1_a = ctx_addr_o;
        @(negedge clk);
    endtask

    task automatic drive_idle();
        start_i = 0; src_valid_i = 0; src_data_i = '0; sisp_stall_i = 0;
        sisp_dout_ready_i = 0; sisp_dout_i = '0;
        mode_i = '0; cfg_i = '0; burst_addr_i = '0; burst_len_i = '0;
        wait_cycles_i = '0; rd_base_i = '0; rd_len_i = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk_v({tag, "_we"},    {71'd0, ctx_we_o},    72'd0);
        chk_v({tag, "_rd"},    {71'd0, ctx_rd_o},    72'd0);
        chk_v({tag, "_ready"}, {71'd0, src_ready_o}, 72'd0);
        chk_v({tag, "_addr"},  {64'd0, ctx_addr_o},  72'd0);
        chk_v({tag, "_data"},  {8'd0, ctx_data_o},   72'd0);
        chk_v({tag, "_rdv"},   {71'd0, rd_valid_o},  72'd0);
        chk_v({tag, "_rdata"}, {8'd0, rd_data_o},    72'd0);
        chk_v({tag, "_busy"},  {71'd0, busy_o},      72'd0);
        chk_v({tag, "_done"},  {71'd0, done_o},      72'd0);
    endtask

    // ---------------- main ----------------
    initial begin
        int wr_at_reset;
        burst_data[0] = 64'h0;
        burst_data[1] = 64'hEFFF_FFFF_FFFF_FFFF;
        burst_data[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 3; i < 12; i++) burst_data[i] = 64'h0;

        //            mode  cfg       ba    bl     wait    rb     rl     st smc gap xr rs  wr rd rdv done fw last
        vecs[0] = mk(6'd1, 64'd7,    8'd119, 8'd12, 16'd4, 8'd140, 8'd20, 0, 0, 0, 0, 0, 14, 20, 20, 42, 1, 159);
        vecs[1] = mk(6'd1, 64'd7,    8'd119, 8'd12, 16'd4, 8'd140, 8'd20, 1, 0, 0, 0, 0, 14, 20, 20, 47, 1, 159);
        vecs[2] = mk(6'd1, 64'd7,    8'd119, 8'd12, 16'd4, 8'd140, 8'd20, 0, 0, 1, 0, 0, 14, 20, 20, 54, 1, 159);
        vecs[3] = mk(6'd4, 64'd9,    8'd33,  8'd0,  16'd0, 8'd10,  8'd0,  0, 0, 0, 0, 0, 2,  0,  0,  3,  1, -1);
        vecs[4] = mk(6'd2, 64'h55,   8'd7,   8'd2,  16'd0, 8'd250, 8'd10, 0, 0, 0, 0, 0, 4,  10, 10, 18, 1, 3);
        vecs[5] = mk(6'd9, 64'hABCD, 8'd119, 8'd12, 16'd4, 8'd140, 8'd20, 0, 0, 0, 1, 1, 14, 20, 20, 42, 1, 159);
        vecs[6] = mk(6'd3, 64'd1,    8'd5,   8'd0,  16'd0, 8'd0,   8'd0,  0, 1, 0, 0, 0, 2,  0,  0,  5,  3, -1);

        drive_idle();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int vi = 0; vi < 7; vi++) begin
            prep(vecs[vi]);
            for (int rel = 0; rel < 300; rel++) begin
                drive_cycle(vecs[vi], rel);
                sample(rel);
                if (done_rel >= 0 && rel >= done_rel + 6) break;
            end
            drive_idle();
            chk_i($sformatf("v%0d_writes", vi), n_wr, vecs[vi].exp_writes);
            chk_i($sformatf("v%0d_reads", vi), n_rd, vecs[vi].exp_reads);
            chk_i($sformatf("v%0d_rd_valid", vi), n_rdv, vecs[vi].exp_rdv);
            chk_i($sformatf("v%0d_done_count", vi), n_done, 1);
            chk_i($sformatf("v%0d_done_cycle", vi), done_rel, vecs[vi].exp_done_rel);
            chk_i($sformatf("v%0d_first_write_cycle", vi), first_wr, vecs[vi].exp_first_wr);
            chk_i($sformatf("v%0d_last_rd_addr", vi), last_rd, vecs[vi].exp_last_rd);
            chk_i($sformatf("v%0d_protocol_violations", vi), viol, 0);
            chk_i($sformatf("v%0d_writes_left", vi), exp_wr_q.size(), 0);
            chk_i($sformatf("v%0d_rdv_left", vi), exp_rdv_q.size(), 0);
            repeat (2) @(negedge clk);
        end

        // Reset during the fifth BURST cycle (cycle 7 after start): outputs clear next cycle, no done.
        prep(vecs[0]);
        for (int rel = 0; rel < 8; rel++) begin
            drive_cycle(vecs[0], rel);
            reset = (rel == 7);
            sample(rel);
        end
        wr_at_reset = n_wr;
        drive_cycle(vecs[0], 8);
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        for (int rel = 9; rel < 60; rel++) begin
            drive_cycle(vecs[0], rel);
            start_i = 1'b0;
            sample(rel);
        end
        chk_i("mid_reset_writes_before", wr_at_reset, 7);
        chk_i("mid_reset_writes_after", n_wr, 7);
        chk_i("mid_reset_reads", n_rd, 0);
        chk_i("mid_reset_done", n_done, 0);
        drive_idle();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sisp_ctx_loader.md
Name: sisp_ctx_loader

Overview:
- Host-side initiator for the SISP context-register interface: drives mode, config, burst and readback traffic into SISP_top, and collects its DataOut stream.
- Takes one descriptor per run and sequences: mode write, config write, burst of streamed data words to one context address, programmable wait, then a readback sweep over a contiguous address range.
- Sits between the host/DMA-side stream logic and SISP_top; replaces hand-sequenced context writes.

Parameters:
- DATA_W, 64, context data width
- ADDR_W, 8, context register address width
- LEN_W, 8, burst/readback length counter width
- WAIT_W, 16, wait counter width
- MODE_ADDR, 140, context address receiving the mode word
- CFG_ADDR, 0, context address receiving the config word

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start_i  in  1  descriptor launch strobe; honoured only in IDLE
- mode_i  in  6  SISP mode code (IDLE=0 … OBJECT_INFO_RSPE=9)
- cfg_i  in  DATA_W  config word
- burst_addr_i  in  ADDR_W  burst target context address
- burst_len_i  in  LEN_W  number of burst words
- wait_cycles_i  in  WAIT_W  idle cycles before readback
- rd_base_i  in  ADDR_W  first readback address
- rd_len_i  in  LEN_W  number of readback words
- src_data_i  in  DATA_W  burst data stream
- src_valid_i  in  1  burst data valid
- src_ready_o  out  1  burst data accepted when valid & ready
- sisp_stall_i  in  1  SISP back-pressure
- ctx_addr_o  out  ADDR_W  to ContextRegAddr_i
- ctx_data_o  out  DATA_W  to DataIn_i
- ctx_we_o  out  1  to DataInReady_i; write strobe
- ctx_rd_o  out  1  readback request strobe
- sisp_dout_i  in  DATA_W  from DataOut_o
- sisp_dout_ready_i  in  1  from DataOutReady_o
- rd_data_o  out  DATA_W  captured readback word
- rd_valid_o  out  1  one-cycle strobe per captured word
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse at end of run

Behaviour:
- Reset: synchronous, active-high; outputs all 0, state IDLE, counters cleared.
- Reset mid-run: abort to IDLE; no done_o; the partial burst is not replayed.
- States: IDLE -> MODE -> CFG -> BURST -> WAIT -> READ -> DRAIN -> DONE -> IDLE.
- IDLE: on start_i, latch all descriptor inputs and go to MODE. start_i while busy is ignored.
- Timing: start at edge N gives ctx_we_o=1 with MODE_ADDR in cycle N+1.
- MODE: one write, ctx_addr_o=MODE_ADDR, ctx_data_o={zero-extend, mode}.
- CFG: one write, ctx_addr_o=CFG_ADDR, ctx_data_o=cfg.
- Stall rule (sisp_stall_i=1), applies in MODE, CFG, BURST and READ:
  - ctx_we_o=0, ctx_rd_o=0, src_ready_o=0;
  - address, data and counters hold;
  - the pending write or read issues on the first unstalled cycle.
- BURST:
  - src_ready_o = ~sisp_stall_i.
  - Each valid&ready cycle writes src_data_i to burst_addr_i, same cycle (combinational pass of data, registered strobe is not allowed; zero added latency).
  - Leave after burst_len words; burst_len=0 skips directly to WAIT.
- WAIT: count wait_cycles cycles with no traffic; 0 means pass through in one cycle.
- READ:
  - Each unstalled cycle, ctx_rd_o=1 and ctx_addr_o = rd_base + issued.
  - Address arithmetic is modulo 2^ADDR_W (255 wraps to 0).
  - After rd_len issues, go to DRAIN; rd_len=0 goes straight to DONE.
- Capture:
  - In READ or DRAIN, every sisp_dout_ready_i=1 registers sisp_dout_i to rd_data_o with rd_valid_o=1 on the next cycle.
  - Returns after rd_len captures are dropped.
  - Returns arriving outside READ/DRAIN are ignored.
- DRAIN: wait until captured==rd_len, then DONE.
- DONE: done_o=1 for one cycle, then IDLE. A new start is accepted the cycle after DONE.

Optional Feature:
- Macro: SISP_CTX_READBACK_CSUM_EN.
- Enabled:
  - adds output csum_o[DATA_W-1:0], the XOR of all captured words in the current run;
  - cleared on start acceptance and on reset;
  - valid when done_o=1, holds until the next start.
- Disabled: the port and the logic are absent; behaviour is otherwise identical.

Test Plan:
- Basic run: mode=1, cfg=7, burst_addr=119, len=12, data {0, EFFFFFFFFFFFFFFF, FFFFFFFFFFFFFFFF, 0×9}, wait=4, rd_base=140, rd_len=20, SISP model returns addr+1000 at latency 2 -> writes (140,1), (0,7), then 12 writes to 119 in order; reads 140..159; rd_data 1140..1159; one done_o.
- Stall: assert sisp_stall_i for 3 cycles in the middle of the burst and 2 cycles in READ -> no write or read during stall; no word lost or duplicated; total write count 14.
- src_valid gaps: drop src_valid_i every other cycle -> writes only on valid cycles; 12 burst writes total.
- Boundaries: burst_len=0, wait=0, rd_len=0 -> only the MODE and CFG writes, then done_o 3 cycles after start. Separately rd_base=250, rd_len=10 -> addresses 250..255, 0..3.
- Protocol robustness: reset in cycle 5 of BURST -> all outputs 0 the next cycle, no done_o. start_i while busy -> ignored, exactly one done_o. Model sends 22 returns -> only 20 rd_valid_o.
- With SISP_CTX_READBACK_CSUM_EN: the first scenario -> csum_o = XOR of 1140..1159 at done_o.
